// File: rtl/morph_filter_3x3.sv
// 3x3 grey-scale morphology (dilate/erode) over a streamed column window.
// Each colour channel is filtered on its own; frame-border pixels pass through unchanged.
module morph_filter_3x3 #(
  parameter int CH_WIDTH   = 8,
  parameter int CHANNELS   = 3,
  parameter int PIC_WIDTH  = 480,
  parameter int PIC_HEIGHT = 272
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         valid_in,
  input  logic [CH_WIDTH*CHANNELS-1:0] din_top,
  input  logic [CH_WIDTH*CHANNELS-1:0] din_mid,
  input  logic [CH_WIDTH*CHANNELS-1:0] din_bot,
  input  logic                         mode,
  input  logic                         shape,
  input  logic                         flush,
  output logic [CH_WIDTH*CHANNELS-1:0] dout,
  output logic                         valid_out
);

  localparam int PW = CH_WIDTH * CHANNELS;
  localparam int CW = $clog2(PIC_WIDTH);
  localparam int RW = $clog2(PIC_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(PIC_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(PIC_HEIGHT - 1);

  // Index 0 is the newest column (right neighbour), index 2 the oldest (left).
  logic [2:0][PW-1:0] top_q, mid_q, bot_q;
  logic [CW-1:0]      icol_q;
  logic [RW-1:0]      irow_q;
  logic               pending_q;
  logic               emit_q;
  logic               border_q;
  logic [PW-1:0]      dout_q;
  logic               valid_q;

  logic               flush_go;
  logic [CW-1:0]      ocol;
  logic [RW-1:0]      orow;
  logic               border_d;
  logic [7:0][PW-1:0] nbr;
  logic [PW-1:0]      filt;
  logic [CH_WIDTH-1:0] cand, cur;

  // valid_in has priority; a flush with nothing pending is a no-op.
  assign flush_go = flush & ~valid_in & pending_q;

  // Centre of the window is one column behind the column just accepted.
  always_comb begin
    ocol = (icol_q == '0) ? COL_LAST : icol_q - 1'b1;
    if (icol_q != '0)
      orow = irow_q;
    else
      orow = (irow_q == '0) ? ROW_LAST : irow_q - 1'b1;
    border_d = (ocol == '0) || (ocol == COL_LAST) || (orow == '0) || (orow == ROW_LAST);
  end

  // Entries 0..3 form the cross arms; 4..7 are the diagonal corners.
  assign nbr = {top_q[0], top_q[2], bot_q[0], bot_q[2],
                top_q[1], bot_q[1], mid_q[0], mid_q[2]};

  always_comb begin
    // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
    filt = mid_q[1];
    cand = '0;
    cur  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int n = 0; n < 8; n++) begin
        if (shape || n < 4) begin
          cand = nbr[n][c*CH_WIDTH +: CH_WIDTH];
          cur  = filt[c*CH_WIDTH +: CH_WIDTH];
          if (mode ? (cand < cur) : (cand > cur))
            filt[c*CH_WIDTH +: CH_WIDTH] = cand;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the window is a handful of flops, not a RAM, so it is reset with everything else.
      top_q     <= '0;
      mid_q     <= '0;
      bot_q     <= '0;
      icol_q    <= '0;
      irow_q    <= '0;
      pending_q <= 1'b0;
      emit_q    <= 1'b0;
      border_q  <= 1'b0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so dout is computed from the window before this edge's shift.
      if (valid_in) begin
        top_q     <= {top_q[1:0], din_top};
        mid_q     <= {mid_q[1:0], din_mid};
        bot_q     <= {bot_q[1:0], din_bot};
        pending_q <= 1'b1;
        emit_q    <= pending_q;
        border_q  <= border_d;
        if (icol_q == COL_LAST) begin
          icol_q <= '0;
          irow_q <= (irow_q == ROW_LAST) ? '0 : irow_q + 1'b1;
        end else begin
          icol_q <= icol_q + 1'b1;
        end
      end else if (flush_go) begin
        top_q     <= {top_q[1:0], {PW{1'b0}}};
        mid_q     <= {mid_q[1:0], {PW{1'b0}}};
        bot_q     <= {bot_q[1:0], {PW{1'b0}}};
        pending_q <= 1'b0;
        emit_q    <= 1'b1;
        border_q  <= border_d;
        icol_q    <= '0;
        irow_q    <= '0;
      end else begin
        emit_q <= 1'b0;
      end

      if (emit_q)
        dout_q <= border_q ? mid_q[1] : filt;
      valid_q <= emit_q;
    end
  end

  assign dout      = dout_q;
  assign valid_out = valid_q;

endmodule

// File: doc/morph_filter_3x3.md
MORPH_FILTER_3X3 -- requirements
Module: morph_filter_3x3

Interface
REQ-001 The block SHALL have parameter CH_WIDTH, default 8, meaning bits per colour channel.
REQ-002 The block SHALL have parameter CHANNELS, default 3, meaning channels per pixel; pixel width PW = CH_WIDTH*CHANNELS.
REQ-003 The block SHALL have parameter PIC_WIDTH, default 480, meaning pixels per line (>=3).
REQ-004 The block SHALL have parameter PIC_HEIGHT, default 272, meaning lines per frame (>=3).
REQ-005 The block SHALL have port clk, input, 1, the clock; all logic on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1, the reset; asynchronous, active-low.
REQ-007 The block SHALL have port valid_in, input, 1, meaning din_top/din_mid/din_bot hold one column.
REQ-008 The block SHALL have ports din_top, din_mid and din_bot, input, PW, meaning rows y-1, y and y+1 of the same column, supplied by external line buffers.
REQ-009 The block SHALL have port mode, input, 1, selecting 0 = dilate (max) or 1 = erode (min).
REQ-010 The block SHALL have port shape, input, 1, selecting 0 = 5-point cross or 1 = 9-point square.
REQ-011 The block SHALL have port flush, input, 1, a pulse that emits the pending pixel and returns to frame start.
REQ-012 The block SHALL have port dout, output, PW, the filtered pixel.
REQ-013 The block SHALL have port valid_out, output, 1, a one-cycle strobe qualifying dout.

Function
REQ-014 Window: 3x3 registers SHALL shift one column on each accepted valid_in (col0<=din, col1<=col0, col2<=col1) and hold otherwise.
REQ-015 Counters: icol (0..PIC_WIDTH-1) and irow (0..PIC_HEIGHT-1) SHALL count accepted pixels.
- icol wraps to 0 after PIC_WIDTH-1, incrementing irow.
- irow wraps to 0 after PIC_HEIGHT-1.
REQ-016 The window centre SHALL be col1 of the middle row, with output coordinates ocol = icol-1, wrapped to PIC_WIDTH-1 with row decrement when icol=0.
REQ-017 A pending flag SHALL set on every accepted pixel.
- An output SHALL be produced for an accepted pixel only if pending was already set.
- The first pixel after reset or flush SHALL produce no output.
REQ-018 Latency: valid_in accepted at edge k SHALL produce valid_out high for exactly the cycle after edge k+1, with dout valid in that same cycle.
REQ-019 Arithmetic SHALL be per channel and unsigned: each CH_WIDTH slice independently takes max (mode 0) or min (mode 1) over the selected neighbourhood; channels never compared as a whole word.
- Cross = centre, left, right, up, down.
- Square = all 9.
REQ-020 Borders: if ocol is 0 or PIC_WIDTH-1, or orow is 0 or PIC_HEIGHT-1, dout SHALL equal the centre pixel unmodified.
REQ-021 mode and shape SHALL be sampled on the edge that computes dout (edge k+1), so they may change between pixels.
REQ-022 Flush with pending set SHALL:
- shift zeros into col0;
- emit the pending pixel with the REQ-018 timing (always a border pixel, therefore pass-through);
- clear pending, icol and irow.
REQ-023 Flush with pending clear SHALL have no effect.
REQ-024 If valid_in and flush are high together, valid_in SHALL win and flush SHALL be ignored.
REQ-025 With valid_in low (and no flush), window, counters and dout SHALL hold, and valid_out SHALL be 0.
REQ-026 Frame wrap without flush: the last pixel of a frame SHALL be emitted when the first pixel of the next frame is accepted, with no gap.

Reset
REQ-027 rst_n low SHALL immediately clear all of the following: window registers, icol, irow, pending, dout and valid_out.
REQ-028 Reset mid-frame SHALL discard the pending pixel; the next accepted pixel is treated as frame pixel (0,0).

Verification
REQ-029 Dilate, cross, CH_WIDTH=8, CHANNELS=1, PIC_WIDTH=4, PIC_HEIGHT=4: interior centre 10, up 50, corner 99 -> dout = 50 (corner ignored); with shape=1 -> dout = 99.
REQ-030 Erode per channel, CHANNELS=3: centre 0x808080, left 0x10FF80, right 0xFF2080 -> dout = 0x102080 (per-channel min), not a whole-word min.
REQ-031 Border: every pixel of row 0, row 3, col 0 and col 3 -> dout equals the centre input; total valid_out count = 16 per frame once flush is included.
REQ-032 Latency and gaps: valid_in high at edge k with gaps of 3 idle cycles -> valid_out high exactly the cycle after edge k+1, once per accepted pixel after the first, never during gaps.
REQ-033 Flush: after 16 pixels, pulse flush -> one valid_out carrying pixel (3,3); the next valid_in produces no valid_out. A flush coincident with valid_in is ignored.
REQ-034 Reset: assert rst_n low mid-line -> dout=0 and valid_out=0 immediately; after release the first pixel gives no output and the second gives output for (0,0).
